reg_file_scb: RTL and testbench
===============================

// Module: reg_file_scb
// PURPOSE
//  Parametrised integer register file, successor to the 2R/1W core regfile.
//  Adds N read ports, a second write port for long-latency units (div, load
//  miss), optional write-to-read bypass and a per-register busy scoreboard
//  for the issue stage's RAW/WAW stalls. Sits between decode/issue and writeback.
// PARAMETERS
//  DATA_W   32  register width in bits
//  NUM_REGS 32  register count (power of 2, >=2); AW = $clog2(NUM_REGS)
//  NUM_RD   2   read ports (1..4)
//  BYPASS   1   1: same-cycle write data forwarded to reads; 0: read old value
// PORTS
//  clk        in   1            rising-edge clock
//  reset      in   1            asynchronous, active-low reset
//  wr0_en     in   1            write port 0 enable (pipeline writeback)
//  wr0_addr   in   AW           write port 0 address
//  wr0_data   in   DATA_W       write port 0 data
//  wr1_en     in   1            write port 1 enable (long-latency unit)
//  wr1_addr   in   AW           write port 1 address
//  wr1_data   in   DATA_W       write port 1 data
//  sb_set_en  in   1            mark register busy (long-latency op issued)
//  sb_set_addr in  AW           register to mark busy
//  rd_addr    in   NUM_RD*AW    read addresses, port i at [i*AW +: AW]
//  rd_data    out  NUM_RD*DATA_W read data, port i at [i*DATA_W +: DATA_W]
//  rd_busy    out  NUM_RD       busy bit of each read address
// BEHAVIOUR
//  - Reset (reset=0, async): all registers <= 0, all busy bits <= 0; thus
//    rd_data = 0 and rd_busy = 0 while held. Writes/sets ignored during reset.
//  - Register 0 hardwired: writes and sb_set to addr 0 ignored; reads of 0
//    return 0 and busy 0, never bypassed.
//  - Writes take effect on rising clk; read path combinational (0-cycle).
//  - Same-address double write (wr0_en & wr1_en, equal addr != 0): wr0 wins
//    (younger instruction); wr1 data dropped, busy still cleared.
//  - Scoreboard: busy[a] set on clk when sb_set_en & a==sb_set_addr; cleared
//    on clk when wr1_en & a==wr1_addr. Set and clear same addr same cycle:
//    set wins (new issue overrides retiring op). wr0 never touches busy.
//  - Re-set of an already busy register: stays busy (no counter; one
//    outstanding long-latency op per register, enforced by issue).
//  - BYPASS=1: if rd_addr[i] matches an enabled write addr (!=0) this cycle,
//    rd_data[i] = that write data (wr0 over wr1 on double match) and
//    rd_busy[i] reflects the post-edge busy value (clear by wr1 -> 0 unless
//    sb_set same addr). BYPASS=0: rd_data/rd_busy show pre-edge state.
//  - Addresses >= NUM_REGS impossible (AW exact); no X on any output.
//  - Reset asserted mid-cycle: contents and busy cleared immediately; a write
//    coincident with reset release edge is not guaranteed; bench avoids it.
// TESTING
//  1 Reset: load r5=0xDEADBEEF, pulse reset low -> rd_data(r5)=0, rd_busy=0.
//  2 x0: wr0 addr0 data 0x1234, sb_set addr0 -> read r0 = 0, busy 0.
//  3 Collision: wr0 r7=0xAAAA_0000 & wr1 r7=0x5555_1111 -> r7=0xAAAA_0000;
//    prior busy[7]=1 cleared.
//  4 Scoreboard: sb_set r3 cycle N -> rd_busy(r3)=1 N+1..; wr1 r3=0x42 cycle
//    M -> BYPASS=1: same cycle data 0x42 busy 0; next cycle data 0x42 busy 0.
//  5 Set/clear race: sb_set r9 & wr1 r9 same cycle -> busy[9]=1 next cycle.
//  6 NUM_RD=4, BYPASS=0: all ports read r2 while wr0 r2=0x99 -> old value,
//    next cycle all 0x99; random traffic vs reference model 10k cycles.

Source files
------------

// File: rtl/reg_file_scb_if.sv
// Register file bus: two write ports, a scoreboard set port, and NUM_RD
// combinational read ports with busy flags.
interface reg_file_scb_if #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32,
  parameter int NUM_RD   = 2
);
  localparam int AW = $clog2(NUM_REGS);

  logic                     wr0_en;
  logic [AW-1:0]            wr0_addr;
  logic [DATA_W-1:0]        wr0_data;
  logic                     wr1_en;
  logic [AW-1:0]            wr1_addr;
  logic [DATA_W-1:0]        wr1_data;
  logic                     sb_set_en;
  logic [AW-1:0]            sb_set_addr;
  logic [NUM_RD*AW-1:0]     rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_busy;

  modport master (
    output wr0_en, wr0_addr, wr0_data,
    output wr1_en, wr1_addr, wr1_data,
    output sb_set_en, sb_set_addr, rd_addr,
    input  rd_data, rd_busy
  );

  modport slave (
    input  wr0_en, wr0_addr, wr0_data,
    input  wr1_en, wr1_addr, wr1_data,
    input  sb_set_en, sb_set_addr, rd_addr,
    output rd_data, rd_busy
  );
endinterface

// File: rtl/reg_file_scb.sv
// Integer register file with two write ports, N combinational read ports,
// optional write-to-read bypass and a per-register busy scoreboard.
module reg_file_scb #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32,
  parameter int NUM_RD   = 2,
  parameter int BYPASS   = 1
) (
  input logic           clk,
  input logic           reset,
  reg_file_scb_if.slave bus
);
  localparam int AW = $clog2(NUM_REGS);

  logic [DATA_W-1:0]   regs [NUM_REGS];
  logic [NUM_REGS-1:0] busy;
  logic [NUM_REGS-1:0] busy_nxt;
  logic                wr0_hit;
  logic                wr1_hit;
  logic                set_hit;

  // Gating with reset keeps held-reset outputs at zero even on the bypass path.
  assign wr0_hit = bus.wr0_en    & reset & (bus.wr0_addr    != '0);
  assign wr1_hit = bus.wr1_en    & reset & (bus.wr1_addr    != '0);
  assign set_hit = bus.sb_set_en & reset & (bus.sb_set_addr != '0);

  // Set is applied after clear so a newly issued op overrides the retiring one.
  always_comb begin
    busy_nxt = busy;
    if (wr1_hit) busy_nxt[bus.wr1_addr]    = 1'b0;
    if (set_hit) busy_nxt[bus.sb_set_addr] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < NUM_REGS; k++) regs[k] <= '0;
      busy <= '0;
    end else begin
      busy <= busy_nxt;
      if (wr1_hit) regs[bus.wr1_addr] <= bus.wr1_data;
      // Later assignment wins: wr0 (younger) beats wr1 on an address collision.
      if (wr0_hit) regs[bus.wr0_addr] <= bus.wr0_data;
    end
  end

  always_comb begin
    logic [AW-1:0]     a;
    logic [DATA_W-1:0] d;
    logic              b;
    bus.rd_data = '0;
    bus.rd_busy = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      a = bus.rd_addr[i*AW +: AW];
      d = regs[a];
      b = busy[a];
      if (BYPASS != 0) begin
        if (wr0_hit && (bus.wr0_addr == a))      d = bus.wr0_data;
        else if (wr1_hit && (bus.wr1_addr == a)) d = bus.wr1_data;
        b = busy_nxt[a];
      end
      if (a == '0) begin
        d = '0;
        b = 1'b0;
      end
      bus.rd_data[i*DATA_W +: DATA_W] = d;
      bus.rd_busy[i]                  = b;
    end
  end
endmodule

// File: tb/tb_reg_file_scb.sv
// Bench for reg_file_scb: a bypassing 2-port instance and a non-bypassing
// 4-port instance share write traffic and are checked against one array model.
module tb_reg_file_scb;
  localparam int DW = 32;
  localparam int NR = 32;
  localparam int AW = 5;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic          w0e = 0, w1e = 0, se = 0;
  logic [AW-1:0] w0a = 0, w1a = 0, sa = 0;
  logic [DW-1:0] w0d = 0, w1d = 0;
  logic [1:0][AW-1:0] ra = '0;
  logic [3:0][AW-1:0] rb = '0;

  int n_vec = 0;
  int n_bad = 0;

  logic [DW-1:0] m_reg [NR];
  bit   [NR-1:0] m_busy;

  reg_file_scb_if #(.DATA_W(DW), .NUM_REGS(NR), .NUM_RD(2)) bus_a ();
  reg_file_scb_if #(.DATA_W(DW), .NUM_REGS(NR), .NUM_RD(4)) bus_b ();

  assign bus_a.wr0_en = w0e;  assign bus_a.wr0_addr = w0a;  assign bus_a.wr0_data = w0d;
  assign bus_a.wr1_en = w1e;  assign bus_a.wr1_addr = w1a;  assign bus_a.wr1_data = w1d;
  assign bus_a.sb_set_en = se; assign bus_a.sb_set_addr = sa; assign bus_a.rd_addr = ra;
  assign bus_b.wr0_en = w0e;  assign bus_b.wr0_addr = w0a;  assign bus_b.wr0_data = w0d;
  assign bus_b.wr1_en = w1e;  assign bus_b.wr1_addr = w1a;  assign bus_b.wr1_data = w1d;
  assign bus_b.sb_set_en = se; assign bus_b.sb_set_addr = sa; assign bus_b.rd_addr = rb;

  reg_file_scb #(.DATA_W(DW), .NUM_REGS(NR), .NUM_RD(2), .BYPASS(1)) dut_a (
    .clk(clk), .reset(reset), .bus(bus_a));
  reg_file_scb #(.DATA_W(DW), .NUM_REGS(NR), .NUM_RD(4), .BYPASS(0)) dut_b (
    .clk(clk), .reset(reset), .bus(bus_b));

  function automatic logic [DW-1:0] rda(input int i);
    return bus_a.rd_data[i*DW +: DW];
  endfunction
  function automatic logic [DW-1:0] rdb(input int i);
    return bus_b.rd_data[i*DW +: DW];
  endfunction

  // Expected read value: stored contents, or (with bypass) this cycle's write.
  function automatic logic [DW-1:0] exp_data(input logic [AW-1:0] a, input bit byp);
    if (a == 0) return '0;
    if (byp && reset) begin
      if (w0e && w0a == a) return w0d;
      if (w1e && w1a == a) return w1d;
    end
    return m_reg[a];
  endfunction

  function automatic logic exp_busy(input logic [AW-1:0] a, input bit byp);
    if (a == 0) return 1'b0;
    if (byp && reset) begin
      if (se && sa == a) return 1'b1;
      if (w1e && w1a == a) return 1'b0;
    end
    return m_busy[a];
  endfunction

  function automatic void model_clear();
    for (int k = 0; k < NR; k++) m_reg[k] = '0;
    m_busy = '0;
  endfunction

  // Advance one clock; commit the architectural effect of the driven inputs.
  task automatic step();
    @(posedge clk);
    if (reset) begin
      if (w1e && w1a != 0) begin m_reg[w1a] = w1d; m_busy[w1a] = 1'b0; end
      if (w0e && w0a != 0) m_reg[w0a] = w0d;
      if (se && sa != 0) m_busy[sa] = 1'b1;
    end
    #1;
    w0e = 0; w1e = 0; se = 0;
  endtask

  task automatic test_reset();
    #2;
    n_vec++;
    if (rda(0) !== '0 || bus_a.rd_busy !== 2'b00) begin
      n_bad++; $display("FAIL reset_init got %h/%b exp 0/00", rda(0), bus_a.rd_busy);
    end
    #1 reset = 1'b1;
    @(posedge clk); #1;
    w0e = 1; w0a = 5; w0d = 32'hDEADBEEF; se = 1; sa = 5;
    step();
    ra[0] = 5; rb[0] = 5; #1;
    n_vec++;
    if (rda(0) !== 32'hDEADBEEF || bus_a.rd_busy[0] !== 1'b1) begin
      n_bad++; $display("FAIL reset_load got %h/%b exp deadbeef/1", rda(0), bus_a.rd_busy[0]);
    end
    reset = 1'b0; model_clear(); #1;
    n_vec++;
    if (rda(0) !== '0 || bus_a.rd_busy[0] !== 1'b0 || rdb(0) !== '0 || bus_b.rd_busy[0] !== 1'b0) begin
      n_bad++; $display("FAIL reset_held got a=%h/%b b=%h/%b exp 0/0", rda(0), bus_a.rd_busy[0], rdb(0), bus_b.rd_busy[0]);
    end
    w0e = 1; w0a = 5; w0d = 32'h1; se = 1; sa = 5; #1;
    n_vec++;
    if (rda(0) !== '0 || bus_a.rd_busy[0] !== 1'b0) begin
      n_bad++; $display("FAIL reset_bypass got %h/%b exp 0/0", rda(0), bus_a.rd_busy[0]);
    end
    step();
    n_vec++;
    if (rda(0) !== '0 || rdb(0) !== '0 || bus_b.rd_busy[0] !== 1'b0) begin
      n_bad++; $display("FAIL reset_write_ignored got a=%h b=%h/%b exp 0", rda(0), rdb(0), bus_b.rd_busy[0]);
    end
    #2 reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_x0();
    w0e = 1; w0a = 0; w0d = 32'h1234; se = 1; sa = 0; ra[0] = 0; rb[0] = 0; #1;
    n_vec++;
    if (rda(0) !== '0 || bus_a.rd_busy[0] !== 1'b0) begin
      n_bad++; $display("FAIL x0_same got %h/%b exp 0/0", rda(0), bus_a.rd_busy[0]);
    end
    step();
    n_vec++;
    if (rda(0) !== '0 || bus_a.rd_busy[0] !== 1'b0 || rdb(0) !== '0 || bus_b.rd_busy[0] !== 1'b0) begin
      n_bad++; $display("FAIL x0_after got a=%h/%b b=%h/%b exp 0/0", rda(0), bus_a.rd_busy[0], rdb(0), bus_b.rd_busy[0]);
    end
  endtask

  task automatic test_collision();
    se = 1; sa = 7; ra[0] = 7; rb[0] = 7;
    step();
    n_vec++;
    if (bus_a.rd_busy[0] !== 1'b1 || bus_b.rd_busy[0] !== 1'b1) begin
      n_bad++; $display("FAIL coll_busy_set got a=%b b=%b exp 1", bus_a.rd_busy[0], bus_b.rd_busy[0]);
    end
    w0e = 1; w0a = 7; w0d = 32'hAAAA_0000; w1e = 1; w1a = 7; w1d = 32'h5555_1111; #1;
    n_vec++;
    if (rda(0) !== 32'hAAAA_0000 || bus_a.rd_busy[0] !== 1'b0) begin
      n_bad++; $display("FAIL coll_bypass got %h/%b exp aaaa0000/0", rda(0), bus_a.rd_busy[0]);
    end
    n_vec++;
    if (rdb(0) !== exp_data(7, 0) || bus_b.rd_busy[0] !== 1'b1) begin
      n_bad++; $display("FAIL coll_nobypass got %h/%b exp %h/1", rdb(0), bus_b.rd_busy[0], exp_data(7, 0));
    end
    step();
    n_vec++;
    if (rda(0) !== 32'hAAAA_0000 || bus_a.rd_busy[0] !== 1'b0 || rdb(0) !== 32'hAAAA_0000 || bus_b.rd_busy[0] !== 1'b0) begin
      n_bad++; $display("FAIL coll_after got a=%h/%b b=%h/%b exp aaaa0000/0", rda(0), bus_a.rd_busy[0], rdb(0), bus_b.rd_busy[0]);
    end
  endtask

  task automatic test_scoreboard();
    ra[0] = 3; rb[0] = 3; se = 1; sa = 3; #1;
    n_vec++;
    if (bus_a.rd_busy[0] !== 1'b1 || bus_b.rd_busy[0] !== 1'b0) begin
      n_bad++; $display("FAIL sb_set_same got a=%b b=%b exp a=1 b=0", bus_a.rd_busy[0], bus_b.rd_busy[0]);
    end
    step(); step();
    n_vec++;
    if (bus_a.rd_busy[0] !== 1'b1 || bus_b.rd_busy[0] !== 1'b1) begin
      n_bad++; $display("FAIL sb_held got a=%b b=%b exp 1", bus_a.rd_busy[0], bus_b.rd_busy[0]);
    end
    se = 1; sa = 3; step();
    n_vec++;
    if (bus_a.rd_busy[0] !== 1'b1) begin
      n_bad++; $display("FAIL sb_reset got %b exp 1", bus_a.rd_busy[0]);
    end
    w1e = 1; w1a = 3; w1d = 32'h42; #1;
    n_vec++;
    if (rda(0) !== 32'h42 || bus_a.rd_busy[0] !== 1'b0 || bus_b.rd_busy[0] !== 1'b1) begin
      n_bad++; $display("FAIL sb_clear_same got a=%h/%b b_busy=%b exp 42/0 b_busy=1", rda(0), bus_a.rd_busy[0], bus_b.rd_busy[0]);
    end
    step();
    n_vec++;
    if (rda(0) !== 32'h42 || bus_a.rd_busy[0] !== 1'b0 || rdb(0) !== 32'h42 || bus_b.rd_busy[0] !== 1'b0) begin
      n_bad++; $display("FAIL sb_clear_after got a=%h/%b b=%h/%b exp 42/0", rda(0), bus_a.rd_busy[0], rdb(0), bus_b.rd_busy[0]);
    end
  endtask

  task automatic test_race();
    ra[0] = 9; rb[0] = 9; se = 1; sa = 9; w1e = 1; w1a = 9; w1d = 32'h77; #1;
    n_vec++;
    if (rda(0) !== 32'h77 || bus_a.rd_busy[0] !== 1'b1) begin
      n_bad++; $display("FAIL race_same got %h/%b exp 77/1", rda(0), bus_a.rd_busy[0]);
    end
    step();
    n_vec++;
    if (bus_a.rd_busy[0] !== 1'b1 || bus_b.rd_busy[0] !== 1'b1 || rdb(0) !== 32'h77) begin
      n_bad++; $display("FAIL race_after got a=%b b=%h/%b exp 77/1", bus_a.rd_busy[0], rdb(0), bus_b.rd_busy[0]);
    end
  endtask

  task automatic test_no_bypass();
    w0e = 1; w0a = 2; w0d = 32'h11; step();
    rb = {AW'(2), AW'(2), AW'(2), AW'(2)};
    w0e = 1; w0a = 2; w0d = 32'h99; #1;
    for (int i = 0; i < 4; i++) begin
      n_vec++;
      if (rdb(i) !== 32'h11) begin
        n_bad++; $display("FAIL nobyp_old port%0d got %h exp 11", i, rdb(i));
      end
    end
    step();
    for (int i = 0; i < 4; i++) begin
      n_vec++;
      if (rdb(i) !== 32'h99) begin
        n_bad++; $display("FAIL nobyp_new port%0d got %h exp 99", i, rdb(i));
      end
    end
  endtask

  function automatic logic [AW-1:0] rnd_addr();
    return ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 7)) : AW'($urandom_range(0, NR - 1));
  endfunction

  task automatic test_random(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      w0e = 1'($urandom_range(0, 1)); w0a = rnd_addr(); w0d = $urandom;
      w1e = 1'($urandom_range(0, 3) == 0); w1a = rnd_addr(); w1d = $urandom;
      se  = 1'($urandom_range(0, 3) == 0); sa = rnd_addr();
      for (int i = 0; i < 2; i++) ra[i] = rnd_addr();
      for (int i = 0; i < 4; i++) rb[i] = rnd_addr();
      #1;
      for (int i = 0; i < 2; i++) begin
        n_vec++;
        if (rda(i) !== exp_data(ra[i], 1) || bus_a.rd_busy[i] !== exp_busy(ra[i], 1)) begin
          n_bad++;
          $display("FAIL rand_byp cyc%0d port%0d addr%0d got %h/%b exp %h/%b", c, i, ra[i],
                   rda(i), bus_a.rd_busy[i], exp_data(ra[i], 1), exp_busy(ra[i], 1));
        end
      end
      for (int i = 0; i < 4; i++) begin
        n_vec++;
        if (rdb(i) !== exp_data(rb[i], 0) || bus_b.rd_busy[i] !== exp_busy(rb[i], 0)) begin
          n_bad++;
          $display("FAIL rand_nobyp cyc%0d port%0d addr%0d got %h/%b exp %h/%b", c, i, rb[i],
                   rdb(i), bus_b.rd_busy[i], exp_data(rb[i], 0), exp_busy(rb[i], 0));
        end
      end
      step();
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_x0();
    test_collision();
    test_scoreboard();
    test_race();
    test_no_bypass();
    test_random(10000);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
